// File: rtl/kd_tree_root_seq_if.sv
// Bundle of the start/status, upstream center source and root-node command/data signals
// that surround the KD-tree root sequencer.
interface kd_tree_root_seq_if;
  logic        start;
  logic [1:0]  axis_in;
  logic [23:0] center_in;
  logic        center_valid;
  logic        center_ready;
  logic [4:0]  command_to_node;
  logic [23:0] data_to_node;
  logic [4:0]  command_from_node;
  logic [23:0] data_from_node;
  logic        busy;
  logic        done;
  logic        error;

  // Driver side: the controller, the center source and the root node.
  modport master (
    output start, axis_in, center_in, center_valid, command_from_node, data_from_node,
    input  center_ready, command_to_node, data_to_node, busy, done, error
  );

  // Sequencer side.
  modport slave (
    input  start, axis_in, center_in, center_valid, command_from_node, data_from_node,
    output center_ready, command_to_node, data_to_node, busy, done, error
  );
endinterface

// File: rtl/kd_tree_root_seq.sv
// Root sequencer: resets the KD tree, streams NUM_CENTERS centers into the root node,
// configures the root sorting axis, then reports done (or a sticky timeout error).
module kd_tree_root_seq #(
  parameter int unsigned NUM_CENTERS = 7,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              rst,
  kd_tree_root_seq_if.slave bus
);

  localparam int unsigned CMD_W  = 5;
  localparam int unsigned DATA_W = 24;
  localparam int unsigned AXIS_W = 2;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned TMO_W  = 8;

  localparam logic [CMD_W-1:0] CMD_NOP          = 5'b00000;
  localparam logic [CMD_W-1:0] CMD_RST          = 5'b11111;
  localparam logic [CMD_W-1:0] CMD_RST_DONE     = 5'b11110;
  localparam logic [CMD_W-1:0] CMD_FILL         = 5'b00001;
  localparam logic [CMD_W-1:0] CMD_FILL_DONE    = 5'b00101;
  localparam logic [CMD_W-1:0] CMD_AXIS         = 5'b00010;
  localparam logic [CMD_W-1:0] CMD_AXIS_DONE    = 5'b00111;
  localparam logic [CMD_W-1:0] CMD_DNE          = 5'b10000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TREE_RST,
    S_FILL,
    S_FILL_WAIT,
    S_AXIS,
    S_FINISH,
    S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [AXIS_W-1:0]   axis_q;
  logic [CMD_W-1:0]    cmd_q;
  logic [DATA_W-1:0]   data_q;
  logic                busy_q, done_q, error_q;

  logic                ready;
  logic                xfer;
  logic                start_ok;
  logic                waiting;
  logic                tmo_hit;
  logic [CMD_W-1:0]    cmd_in;

  assign cmd_in   = bus.command_from_node;
  // Ready drops combinationally once the last center has been counted.
  assign ready    = (state_q == S_FILL) && (count_q != CNT_W'(NUM_CENTERS));
  assign xfer     = ready && bus.center_valid;
  assign start_ok = (state_q == S_IDLE) && bus.start;
  assign waiting  = state_q inside {S_TREE_RST, S_FILL_WAIT, S_AXIS};
  assign tmo_hit  = (tmo_q == TMO_W'(TIMEOUT - 1));

  // Next-state, center count and phase timeout.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_TREE_RST;
          count_d = '0;
        end
      end
      S_TREE_RST: begin
        if (cmd_in == CMD_RST_DONE || cmd_in == CMD_DNE) state_d = S_FILL;
        else if (tmo_hit)                                state_d = S_ERR;
      end
      S_FILL: begin
        if (xfer) count_d = count_q + CNT_W'(1);
        if (count_d == CNT_W'(NUM_CENTERS)) state_d = S_FILL_WAIT;
      end
      S_FILL_WAIT: begin
        if (cmd_in == CMD_FILL_DONE || cmd_in == CMD_DNE) state_d = S_AXIS;
        else if (tmo_hit)                                 state_d = S_ERR;
      end
      S_AXIS: begin
        if (cmd_in == CMD_AXIS_DONE || cmd_in == CMD_DNE) state_d = S_FINISH;
        else if (tmo_hit)                                 state_d = S_ERR;
      end
      S_FINISH: state_d = S_IDLE;
      S_ERR:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    tmo_d = (state_d != state_q) ? '0 : (waiting ? tmo_q + TMO_W'(1) : tmo_q);
  end

  // State and registered outputs, decoded from the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      tmo_q   <= '0;
      axis_q  <= '0;
      cmd_q   <= CMD_NOP;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tmo_q   <= tmo_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_FINISH);
      if (start_ok) axis_q <= bus.axis_in;
      if (state_d == S_ERR) error_q <= 1'b1;
      else if (start_ok)    error_q <= 1'b0;
      case (state_d)
        S_TREE_RST: begin
          cmd_q  <= CMD_RST;
          data_q <= '0;
        end
        S_FILL: begin
          cmd_q <= xfer ? CMD_FILL : CMD_NOP;
          if (xfer) data_q <= bus.center_in;
        end
        // The last center keeps being presented until the node acknowledges the fill.
        S_FILL_WAIT: begin
          cmd_q <= CMD_FILL;
          if (xfer) data_q <= bus.center_in;
        end
        S_AXIS: begin
          cmd_q  <= CMD_AXIS;
          data_q <= {{(DATA_W-AXIS_W){1'b0}}, axis_q};
        end
        default: begin
          cmd_q  <= CMD_NOP;
          data_q <= '0;
        end
      endcase
    end
  end

  assign bus.center_ready    = ready;
  assign bus.command_to_node = cmd_q;
  assign bus.data_to_node    = data_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.error           = error_q;

endmodule
